// File: rtl/target_byte_packer.sv
// rtl/target_byte_packer.sv - packs right-justified variable-length byte beats into full 64-bit words
module target_byte_packer #(
    parameter int DW = 64,
    parameter int BW = DW / 8
) (
    input  logic          log_clk,
    input  logic          log_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_bus_en,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_bcnt,
    output logic          out_last
);

    localparam int RW = DW - 8;      // residue holds at most 7 bytes
    localparam int CW = DW + RW;     // residue plus one full beat

    typedef enum logic {ACC, FLUSH} state_t;

    state_t          state, state_next;
    logic [RW-1:0]   res_data, res_next;
    logic [2:0]      res_cnt, cnt_next;

    logic [3:0]      n;
    logic [DW-1:0]   byte_mask;
    logic [DW-1:0]   masked;
    logic [CW-1:0]   cat;
    logic [4:0]      t;
    logic            slot_free;
    logic            accept;

    logic            emit;
    logic [DW-1:0]   emit_data;
    logic [3:0]      emit_bcnt;
    logic            emit_last;

    // Byte count follows the highest set enable, matching the aligner's view.
    always_comb begin
        n = 4'd0;
        casez (in_bus_en)
            8'b1???????: n = 4'd8;
            8'b01??????: n = 4'd7;
            8'b001?????: n = 4'd6;
            8'b0001????: n = 4'd5;
            8'b00001???: n = 4'd4;
            8'b000001??: n = 4'd3;
            8'b0000001?: n = 4'd2;
            8'b00000001: n = 4'd1;
            default:     n = 4'd0;
        endcase
    end

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < BW; i++) begin
            byte_mask[8*i +: 8] = (n > 4'(i)) ? 8'hFF : 8'h00;
        end
    end

    assign masked    = in_data & byte_mask;
    assign cat       = ({{(CW-DW){1'b0}}, masked} << {res_cnt, 3'b000}) | {{DW{1'b0}}, res_data};
    assign t         = {2'b00, res_cnt} + {1'b0, n};
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == ACC) && slot_free;
    assign accept    = in_valid && in_ready;

    // Residue bytes above res_cnt are always zero, so the concatenation needs no extra masking.
    always_comb begin
        state_next = state;
        res_next   = res_data;
        cnt_next   = res_cnt;
        emit       = 1'b0;
        emit_data  = '0;
        emit_bcnt  = 4'd0;
        emit_last  = 1'b0;
        case (state)
            ACC: begin
                if (accept) begin
                    if ((t < 5'd8) && !in_last) begin
                        res_next = cat[RW-1:0];
                        cnt_next = t[2:0];
                    end else if (t <= 5'd8) begin
                        emit      = 1'b1;
                        emit_data = cat[DW-1:0];
                        emit_bcnt = t[3:0];
                        emit_last = in_last;
                        res_next  = '0;
                        cnt_next  = 3'd0;
                    end else begin
                        // t is 9..15 here, so t[2:0] equals the leftover byte count.
                        emit      = 1'b1;
                        emit_data = cat[DW-1:0];
                        emit_bcnt = 4'd8;
                        emit_last = 1'b0;
                        res_next  = cat[CW-1:DW];
                        cnt_next  = t[2:0];
                        if (in_last) begin
                            state_next = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit       = 1'b1;
                    emit_data  = {{(DW-RW){1'b0}}, res_data};
                    emit_bcnt  = {1'b0, res_cnt};
                    emit_last  = 1'b1;
                    res_next   = '0;
                    cnt_next   = 3'd0;
                    state_next = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state     <= ACC;
            res_data  <= '0;
            res_cnt   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bcnt  <= 4'd0;
            out_last  <= 1'b0;
        end else begin
            state    <= state_next;
            res_data <= res_next;
            res_cnt  <= cnt_next;
            if (slot_free) begin
                out_valid <= emit;
                out_data  <= emit_data;
                out_bcnt  <= emit_bcnt;
                out_last  <= emit_last;
            end
        end
    end

endmodule
